// File: rtl/ascon_msg_feeder.sv
// Ascon hash message front-end: packs a length-prefixed byte stream into padded 64-bit rate blocks.
// Define ASCON_FEEDER_LE_EN for little-endian slot packing with pad byte 0x01.
module ascon_msg_feeder #(
    parameter int BW = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    input  logic [7:0]    cmd_len,
    output logic          cmd_ready,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          start,
    output logic [7:0]    msg_length,
    output logic [BW-1:0] block_out,
    output logic          block_valid,
    input  logic          block_ready,
    output logic          busy
);

    if (BW != 64) begin : g_bw_check
        $error("ascon_msg_feeder: only BW = 64 is supported");
    end

`ifdef ASCON_FEEDER_LE_EN
    localparam logic [7:0] PAD = 8'h01;
`else
    localparam logic [7:0] PAD = 8'h80;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_FILL,
        S_EMIT
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    len_q, len_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          last_q, last_d;
    logic [5:0]    slot_lsb;

    // Bit offset of the slot addressed by idx; idx never exceeds 7 while filling.
    always_comb begin
`ifdef ASCON_FEEDER_LE_EN
        slot_lsb = {idx_q[2:0], 3'b000};
`else
        slot_lsb = {~idx_q[2:0], 3'b000};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        len_d   = len_q;
        blk_d   = blk_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_START;
                    len_d   = cmd_len;
                    rem_d   = cmd_len;
                    idx_d   = '0;
                    blk_d   = '0;
                    last_d  = 1'b0;
                end
            end
            S_START: state_d = S_FILL;
            S_FILL: begin
                if (rem_q != 8'd0) begin
                    if (byte_valid) begin
                        blk_d[slot_lsb +: 8] = byte_in;
                        idx_d = idx_q + 4'd1;
                        rem_d = rem_q - 8'd1;
                        if (idx_q == 4'd7) begin
                            state_d = S_EMIT;
                            last_d  = 1'b0;
                        end
                    end
                end else begin
                    // Slots above idx are still zero from the last clear.
                    blk_d[slot_lsb +: 8] = PAD;
                    state_d = S_EMIT;
                    last_d  = 1'b1;
                end
            end
            S_EMIT: begin
                if (block_ready) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        blk_d   = '0;
                        idx_d   = '0;
                        state_d = S_FILL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign start       = (state_q == S_START);
    assign byte_ready  = (state_q == S_FILL) && (rem_q != 8'd0);
    assign block_valid = (state_q == S_EMIT);
    assign block_out   = blk_q;
    assign msg_length  = len_q;

endmodule

// File: tb/tb_ascon_msg_feeder.sv
// Randomized self-checking bench for ascon_msg_feeder against a byte-array padding model.
module tb_ascon_msg_feeder;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic [7:0]  cmd_len;
    logic        cmd_ready;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        start;
    logic [7:0]  msg_length;
    logic [63:0] block_out;
    logic        block_valid;
    logic        block_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  msg [0:255];
    logic [63:0] exp_blocks [$];
    logic [63:0] obs_blocks [$];
    int          obs_start_cnt, obs_start_cyc, obs_first_valid;
    int          obs_unstable, obs_extra, obs_busy_fall, obs_cycles;
    logic [7:0]  obs_start_len;

    localparam int MAX_CYC = 3000;

    ascon_msg_feeder #(.BW(64)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .start(start), .msg_length(msg_length),
        .block_out(block_out), .block_valid(block_valid), .block_ready(block_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected blocks: byte i goes to block i/8, slot i%8; pad at index len.
    task automatic model(input int len);
        logic [63:0] blk;
        logic [7:0]  v;
        int          i;
`ifdef ASCON_FEEDER_LE_EN
        logic [7:0]  pad = 8'h01;
`else
        logic [7:0]  pad = 8'h80;
`endif
        exp_blocks.delete();
        for (int b = 0; b <= len / 8; b++) begin
            blk = '0;
            for (int s = 0; s < 8; s++) begin
                i = b * 8 + s;
                v = (i < len) ? msg[i] : (i == len) ? pad : 8'h00;
`ifdef ASCON_FEEDER_LE_EN
                blk[8*s +: 8] = v;
`else
                blk[63-8*s -: 8] = v;
`endif
            end
            exp_blocks.push_back(blk);
        end
    endtask

    // Runs one message; cycle 1 is the cycle after the command edge.
    task automatic drive_msg(input int len, input int gap_pct, input int stall, input bit extra);
        int          sent, cyc, stall_left, last_hs;
        bit          holding;
        logic [63:0] held;
        obs_blocks.delete();
        obs_start_cnt = 0; obs_start_cyc = -1; obs_start_len = '0; obs_first_valid = -1;
        obs_unstable = 0; obs_extra = 0;
        held = '0; holding = 1'b0; last_hs = -1;
        cmd_valid = 1'b1; cmd_len = len[7:0];
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1; sent = 0; stall_left = stall;
        while (cyc < MAX_CYC) begin
            if (start) begin
                obs_start_cnt++; obs_start_cyc = cyc; obs_start_len = msg_length;
            end
            if (!busy) break;
            byte_valid = 1'b0;
            if (sent < len) begin
                if ($urandom_range(99) >= gap_pct) begin
                    byte_valid = 1'b1; byte_in = msg[sent];
                end
            end else if (extra) begin
                byte_valid = 1'b1; byte_in = 8'hee;
            end
            if (byte_valid && byte_ready) begin
                if (sent < len) sent++;
                else obs_extra++;
            end
            block_ready = 1'b0;
            if (block_valid) begin
                if (obs_first_valid < 0) obs_first_valid = cyc;
                if (!holding) begin
                    held = block_out; holding = 1'b1;
                end else if (block_out !== held) begin
                    obs_unstable++;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    block_ready = 1'b1;
                    obs_blocks.push_back(block_out);
                    holding = 1'b0; stall_left = stall; last_hs = cyc;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        obs_cycles    = cyc;
        obs_busy_fall = cyc - last_hs;
        byte_valid  = 1'b0;
        block_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (cmd_ready !== 1'b1)   begin bad++; $display("FAIL reset cmd_ready got %b want 1", cmd_ready); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset busy got %b want 0", busy); end
        total++; if (start !== 1'b0)       begin bad++; $display("FAIL reset start got %b want 0", start); end
        total++; if (byte_ready !== 1'b0)  begin bad++; $display("FAIL reset byte_ready got %b want 0", byte_ready); end
        total++; if (block_valid !== 1'b0) begin bad++; $display("FAIL reset block_valid got %b want 0", block_valid); end
        total++; if (msg_length !== 8'h00) begin bad++; $display("FAIL reset msg_length got %h want 00", msg_length); end
        total++; if (block_out !== 64'h0)  begin bad++; $display("FAIL reset block_out got %h want 0", block_out); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input string name, input int len, input bit extra);
        int exp_first;
        model(len);
        drive_msg(len, 0, 0, extra);
        exp_first = (len >= 8) ? 10 : len + 3;
        total++; if (obs_cycles >= MAX_CYC) begin bad++; $display("FAIL %s timeout got %0d cycles want <%0d", name, obs_cycles, MAX_CYC); end
        total++; if (obs_start_cnt !== 1 || obs_start_cyc !== 1) begin bad++; $display("FAIL %s start got cnt=%0d cyc=%0d want cnt=1 cyc=1", name, obs_start_cnt, obs_start_cyc); end
        total++; if (obs_start_len !== len[7:0]) begin bad++; $display("FAIL %s start_len got %0d want %0d", name, obs_start_len, len); end
        total++; if (obs_first_valid !== exp_first) begin bad++; $display("FAIL %s first_valid got %0d want %0d", name, obs_first_valid, exp_first); end
        total++; if (obs_blocks.size() !== exp_blocks.size()) begin bad++; $display("FAIL %s nblocks got %0d want %0d", name, obs_blocks.size(), exp_blocks.size()); end
        for (int i = 0; i < exp_blocks.size() && i < obs_blocks.size(); i++) begin
            total++; if (obs_blocks[i] !== exp_blocks[i]) begin bad++; $display("FAIL %s block%0d got %h want %h", name, i, obs_blocks[i], exp_blocks[i]); end
        end
        total++; if (obs_extra !== 0) begin bad++; $display("FAIL %s extra_bytes got %0d want 0", name, obs_extra); end
        total++; if (obs_busy_fall !== 1) begin bad++; $display("FAIL %s busy_fall got %0d want 1", name, obs_busy_fall); end
        total++; if (msg_length !== len[7:0] || cmd_ready !== 1'b1) begin bad++; $display("FAIL %s idle got len=%0d rdy=%b want len=%0d rdy=1", name, msg_length, cmd_ready, len); end
    endtask

    task automatic test_len0();
        test_basic("len0", 0, 1'b0);
        total++;
`ifdef ASCON_FEEDER_LE_EN
        if (obs_blocks.size() < 1 || obs_blocks[0] !== 64'h0000000000000001) begin bad++; $display("FAIL len0 const got %h want 0000000000000001", (obs_blocks.size() > 0) ? obs_blocks[0] : 64'h0); end
`else
        if (obs_blocks.size() < 1 || obs_blocks[0] !== 64'h8000000000000000) begin bad++; $display("FAIL len0 const got %h want 8000000000000000", (obs_blocks.size() > 0) ? obs_blocks[0] : 64'h0); end
`endif
    endtask

    task automatic test_len3();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        test_basic("len3", 3, 1'b1);
        total++;
`ifdef ASCON_FEEDER_LE_EN
        if (obs_blocks.size() < 1 || obs_blocks[0] !== 64'h0000000001636261) begin bad++; $display("FAIL len3 const got %h want 0000000001636261", (obs_blocks.size() > 0) ? obs_blocks[0] : 64'h0); end
`else
        if (obs_blocks.size() < 1 || obs_blocks[0] !== 64'h6162638000000000) begin bad++; $display("FAIL len3 const got %h want 6162638000000000", (obs_blocks.size() > 0) ? obs_blocks[0] : 64'h0); end
`endif
    endtask

    task automatic test_len8();
        for (int i = 0; i < 8; i++) msg[i] = 8'(i + 1);
        test_basic("len8", 8, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 13; i++) msg[i] = 8'($urandom_range(255));
        model(13);
        drive_msg(13, 40, 5, 1'b0);
        total++; if (obs_cycles >= MAX_CYC) begin bad++; $display("FAIL stall timeout got %0d want <%0d", obs_cycles, MAX_CYC); end
        total++; if (obs_blocks.size() !== 2) begin bad++; $display("FAIL stall nblocks got %0d want 2", obs_blocks.size()); end
        for (int i = 0; i < 2 && i < obs_blocks.size(); i++) begin
            total++; if (obs_blocks[i] !== exp_blocks[i]) begin bad++; $display("FAIL stall block%0d got %h want %h", i, obs_blocks[i], exp_blocks[i]); end
        end
        total++; if (obs_unstable !== 0) begin bad++; $display("FAIL stall stable got %0d changes want 0", obs_unstable); end
        total++; if (obs_busy_fall !== 1) begin bad++; $display("FAIL stall busy_fall got %0d want 1", obs_busy_fall); end
    endtask

    task automatic test_reset_mid();
        int sent, guard, stray;
        for (int i = 0; i < 20; i++) msg[i] = 8'($urandom_range(255));
        cmd_valid = 1'b1; cmd_len = 8'd20;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        sent = 0; guard = 0; block_ready = 1'b1;
        while (sent < 10 && guard < 100) begin
            byte_valid = 1'b1; byte_in = msg[sent];
            if (byte_ready) sent++;
            @(posedge clk); #1;
            guard++;
        end
        byte_valid = 1'b0; block_ready = 1'b0;
        total++; if (sent !== 10) begin bad++; $display("FAIL rstmid bytes got %0d want 10", sent); end
        rstn = 1'b0;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid idle got rdy=%b busy=%b want 1 0", cmd_ready, busy); end
        total++; if (block_valid !== 1'b0 || block_out !== 64'h0 || msg_length !== 8'h0) begin bad++; $display("FAIL rstmid regs got v=%b blk=%h len=%h want 0", block_valid, block_out, msg_length); end
        rstn = 1'b1;
        stray = 0;
        repeat (6) begin
            byte_valid = 1'b1; block_ready = 1'b1;
            @(posedge clk); #1;
            if (start || block_valid || busy) stray++;
        end
        byte_valid = 1'b0; block_ready = 1'b0;
        total++; if (stray !== 0) begin bad++; $display("FAIL rstmid stray got %0d want 0", stray); end
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        test_basic("rstmid_next", 3, 1'b0);
    endtask

    task automatic test_random();
        int len, stall;
        for (int n = 0; n < 8; n++) begin
            len   = $urandom_range(40);
            stall = $urandom_range(3);
            for (int i = 0; i < len; i++) msg[i] = 8'($urandom_range(255));
            model(len);
            drive_msg(len, 30, stall, n[0]);
            total++; if (obs_blocks.size() !== exp_blocks.size()) begin bad++; $display("FAIL rand%0d nblocks got %0d want %0d", n, obs_blocks.size(), exp_blocks.size()); end
            for (int i = 0; i < exp_blocks.size() && i < obs_blocks.size(); i++) begin
                total++; if (obs_blocks[i] !== exp_blocks[i]) begin bad++; $display("FAIL rand%0d block%0d got %h want %h", n, i, obs_blocks[i], exp_blocks[i]); end
            end
            total++; if (obs_unstable !== 0 || obs_extra !== 0) begin bad++; $display("FAIL rand%0d hs got unstable=%0d extra=%0d want 0 0", n, obs_unstable, obs_extra); end
            total++; if (obs_start_cnt !== 1 || obs_start_len !== len[7:0]) begin bad++; $display("FAIL rand%0d start got cnt=%0d len=%0d want 1 %0d", n, obs_start_cnt, obs_start_len, len); end
        end
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
        byte_in = '0; byte_valid = 1'b0; block_ready = 1'b0;
        test_reset();
        test_len0();
        test_len3();
        test_len8();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
